// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch-stage control inputs and PC outputs of the PC sequencer
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            fetch_ready;
    logic            exc;
    logic            br_taken;
    logic [XLEN-1:0] br;
    logic            jr;
    logic [XLEN-1:0] rind;
    logic            jump;
    logic [XLEN-1:0] jabs;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;
    logic            fetch_valid;
    logic            redirect_pend;
    logic            misalign;

    modport master (
        output stall, fetch_ready, exc, br_taken, br, jr, rind, jump, jabs,
        input  pc, pc_plus_4, fetch_valid, redirect_pend, misalign
    );

    modport slave (
        input  stall, fetch_ready, exc, br_taken, br, jr, rind, jump, jabs,
        output pc, pc_plus_4, fetch_valid, redirect_pend, misalign
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with prioritised next-PC select and held-redirect slot
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'('h80),
    parameter int              INSTR_BYTES  = 4
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    localparam logic [XLEN-1:0] INC        = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    localparam logic [1:0] PRIO_EXC  = 2'd3;
    localparam logic [1:0] PRIO_BR   = 2'd2;
    localparam logic [1:0] PRIO_JR   = 2'd1;
    localparam logic [1:0] PRIO_JUMP = 2'd0;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            fetch_valid_q;
    logic            pend_vld_q, pend_vld_d;
    logic [1:0]      pend_prio_q, pend_prio_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic            misalign_q, misalign_d;

    logic            jr_mis;
    logic            live_vld;
    logic [1:0]      live_prio;
    logic [XLEN-1:0] live_tgt;
    logic            advance;
    logic [XLEN-1:0] pc_inc;

    assign pc_inc  = pc_q + INC;
    assign advance = fetch_valid_q & bus.fetch_ready & ~bus.stall;
    assign jr_mis  = bus.jr & ((bus.rind & ALIGN_MASK) != '0);

    // A misaligned indirect jump is promoted to exception priority before arbitration.
    always_comb begin
        live_vld  = bus.exc | bus.br_taken | bus.jr | bus.jump;
        live_prio = PRIO_JUMP;
        live_tgt  = bus.jabs;
        if (bus.exc || jr_mis) begin
            live_prio = PRIO_EXC;
            live_tgt  = EXC_VECTOR;
        end else if (bus.br_taken) begin
            live_prio = PRIO_BR;
            live_tgt  = bus.br;
        end else if (bus.jr) begin
            live_prio = PRIO_JR;
            live_tgt  = bus.rind;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        pend_vld_d  = pend_vld_q;
        pend_prio_d = pend_prio_q;
        pend_tgt_d  = pend_tgt_q;
        misalign_d  = jr_mis;
        if (advance) begin
            pend_vld_d  = 1'b0;
            pend_prio_d = '0;
            pend_tgt_d  = '0;
            // Held redirect wins only when strictly higher; a tie goes to the live request.
            if (pend_vld_q && (!live_vld || pend_prio_q > live_prio)) begin
                pc_d = pend_tgt_q;
            end else if (live_vld) begin
                pc_d = live_tgt;
            end else begin
                pc_d = pc_inc;
            end
        end else if (live_vld && (!pend_vld_q || live_prio >= pend_prio_q)) begin
            pend_vld_d  = 1'b1;
            pend_prio_d = live_prio;
            pend_tgt_d  = live_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            pend_vld_q    <= 1'b0;
            pend_prio_q   <= '0;
            pend_tgt_q    <= '0;
            misalign_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            fetch_valid_q <= 1'b1;
            pend_vld_q    <= pend_vld_d;
            pend_prio_q   <= pend_prio_d;
            pend_tgt_q    <= pend_tgt_d;
            misalign_q    <= misalign_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus_4     = pc_inc;
    assign bus.fetch_valid   = fetch_valid_q;
    assign bus.redirect_pend = pend_vld_q;
    assign bus.misalign      = misalign_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scenario bench for pc_sequencer with an expected-output queue
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.XLEN(32)) bus ();

    pc_sequencer #(
        .XLEN(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h80), .INSTR_BYTES(4)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct packed {
        logic rst, stall, rdy, exc, brt;
        logic [31:0] br;
        logic jr;
        logic [31:0] rind;
        logic jump;
        logic [31:0] jabs;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic pend, mis, fv;
    } exp_t;

    exp_t sb[$];

    function automatic stim_t s(logic rst, logic stall, logic rdy, logic exc, logic brt,
                                logic [31:0] br, logic jr, logic [31:0] rind,
                                logic jump, logic [31:0] jabs);
        stim_t r;
        r.rst = rst; r.stall = stall; r.rdy = rdy; r.exc = exc; r.brt = brt; r.br = br;
        r.jr = jr; r.rind = rind; r.jump = jump; r.jabs = jabs;
        return r;
    endfunction

    function automatic exp_t x(logic [31:0] pc, logic pend, logic mis, logic fv);
        exp_t r;
        r.pc = pc; r.pend = pend; r.mis = mis; r.fv = fv;
        return r;
    endfunction

    function automatic stim_t idle();
        return s(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic drive(input stim_t st);
        reset           = st.rst;
        bus.stall       = st.stall;
        bus.fetch_ready = st.rdy;
        bus.exc         = st.exc;
        bus.br_taken    = st.brt;
        bus.br          = st.br;
        bus.jr          = st.jr;
        bus.rind        = st.rind;
        bus.jump        = st.jump;
        bus.jabs        = st.jabs;
    endtask

    task automatic test_reset();
        stim_t sq[$];
        exp_t  xq[$];
        exp_t  e;
        logic [31:0] p4;
        sq.push_back(s(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));           xq.push_back(x(32'h0, 0, 0, 0));
        sq.push_back(s(1, 0, 1, 0, 0, 0, 0, 0, 1, 32'h55));      xq.push_back(x(32'h0, 0, 0, 0));
        sq.push_back(idle());                                    xq.push_back(x(32'h0, 0, 0, 1));
        sq.push_back(idle());                                    xq.push_back(x(32'h4, 0, 0, 1));
        sq.push_back(idle());                                    xq.push_back(x(32'h8, 0, 0, 1));
        sq.push_back(idle());                                    xq.push_back(x(32'hC, 0, 0, 1));
        foreach (sq[i]) begin
            drive(sq[i]); sb.push_back(xq[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); p4 = e.pc + 32'd4;
            checks++; if (bus.pc !== e.pc) begin failures++; $display("FAIL reset[%0d] pc got=%h exp=%h", i, bus.pc, e.pc); end
            checks++; if (bus.pc_plus_4 !== p4) begin failures++; $display("FAIL reset[%0d] pc_plus_4 got=%h exp=%h", i, bus.pc_plus_4, p4); end
            checks++; if (bus.redirect_pend !== e.pend) begin failures++; $display("FAIL reset[%0d] redirect_pend got=%b exp=%b", i, bus.redirect_pend, e.pend); end
            checks++; if (bus.misalign !== e.mis) begin failures++; $display("FAIL reset[%0d] misalign got=%b exp=%b", i, bus.misalign, e.mis); end
            checks++; if (bus.fetch_valid !== e.fv) begin failures++; $display("FAIL reset[%0d] fetch_valid got=%b exp=%b", i, bus.fetch_valid, e.fv); end
        end
    endtask

    task automatic test_branch_priority();
        stim_t sq[$];
        exp_t  xq[$];
        exp_t  e;
        logic [31:0] p4;
        sq.push_back(idle());                                          xq.push_back(x(32'h10, 0, 0, 1));
        sq.push_back(s(0, 0, 1, 0, 1, 32'h200, 0, 0, 1, 32'h300));     xq.push_back(x(32'h200, 0, 0, 1));
        sq.push_back(idle());                                          xq.push_back(x(32'h204, 0, 0, 1));
        foreach (sq[i]) begin
            drive(sq[i]); sb.push_back(xq[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); p4 = e.pc + 32'd4;
            checks++; if (bus.pc !== e.pc) begin failures++; $display("FAIL branch[%0d] pc got=%h exp=%h", i, bus.pc, e.pc); end
            checks++; if (bus.pc_plus_4 !== p4) begin failures++; $display("FAIL branch[%0d] pc_plus_4 got=%h exp=%h", i, bus.pc_plus_4, p4); end
            checks++; if (bus.redirect_pend !== e.pend) begin failures++; $display("FAIL branch[%0d] redirect_pend got=%b exp=%b", i, bus.redirect_pend, e.pend); end
            checks++; if (bus.misalign !== e.mis) begin failures++; $display("FAIL branch[%0d] misalign got=%b exp=%b", i, bus.misalign, e.mis); end
        end
    endtask

    task automatic test_stall_hold();
        stim_t sq[$];
        exp_t  xq[$];
        exp_t  e;
        sq.push_back(s(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h20));            xq.push_back(x(32'h20, 0, 0, 1));
        sq.push_back(s(0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h400));           xq.push_back(x(32'h20, 1, 0, 1));
        for (int k = 0; k < 3; k++) begin
            sq.push_back(s(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));             xq.push_back(x(32'h20, 1, 0, 1));
        end
        sq.push_back(idle());                                          xq.push_back(x(32'h400, 0, 0, 1));
        sq.push_back(idle());                                          xq.push_back(x(32'h404, 0, 0, 1));
        foreach (sq[i]) begin
            drive(sq[i]); sb.push_back(xq[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++; if (bus.pc !== e.pc) begin failures++; $display("FAIL stall[%0d] pc got=%h exp=%h", i, bus.pc, e.pc); end
            checks++; if (bus.redirect_pend !== e.pend) begin failures++; $display("FAIL stall[%0d] redirect_pend got=%b exp=%b", i, bus.redirect_pend, e.pend); end
            checks++; if (bus.fetch_valid !== e.fv) begin failures++; $display("FAIL stall[%0d] fetch_valid got=%b exp=%b", i, bus.fetch_valid, e.fv); end
        end
    endtask

    task automatic test_pending_priority();
        stim_t sq[$];
        exp_t  xq[$];
        exp_t  e;
        sq.push_back(s(0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h500));           xq.push_back(x(32'h404, 1, 0, 1));
        sq.push_back(s(0, 1, 1, 1, 0, 0, 0, 0, 0, 0));                 xq.push_back(x(32'h404, 1, 0, 1));
        sq.push_back(idle());                                          xq.push_back(x(32'h80, 0, 0, 1));
        sq.push_back(s(0, 1, 1, 1, 0, 0, 0, 0, 0, 0));                 xq.push_back(x(32'h80, 1, 0, 1));
        sq.push_back(s(0, 1, 1, 0, 1, 32'h600, 0, 0, 0, 0));           xq.push_back(x(32'h80, 1, 0, 1));
        sq.push_back(idle());                                          xq.push_back(x(32'h80, 0, 0, 1));
        sq.push_back(s(0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h700));           xq.push_back(x(32'h80, 1, 0, 1));
        sq.push_back(s(0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h710));           xq.push_back(x(32'h80, 1, 0, 1));
        sq.push_back(idle());                                          xq.push_back(x(32'h710, 0, 0, 1));
        sq.push_back(s(0, 0, 0, 0, 1, 32'h800, 0, 0, 0, 0));           xq.push_back(x(32'h710, 1, 0, 1));
        sq.push_back(s(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h900));           xq.push_back(x(32'h800, 0, 0, 1));
        sq.push_back(s(0, 1, 1, 0, 0, 0, 0, 0, 1, 32'hA00));           xq.push_back(x(32'h800, 1, 0, 1));
        sq.push_back(s(0, 0, 1, 0, 1, 32'hB00, 0, 0, 0, 0));           xq.push_back(x(32'hB00, 0, 0, 1));
        sq.push_back(idle());                                          xq.push_back(x(32'hB04, 0, 0, 1));
        foreach (sq[i]) begin
            drive(sq[i]); sb.push_back(xq[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++; if (bus.pc !== e.pc) begin failures++; $display("FAIL pending[%0d] pc got=%h exp=%h", i, bus.pc, e.pc); end
            checks++; if (bus.redirect_pend !== e.pend) begin failures++; $display("FAIL pending[%0d] redirect_pend got=%b exp=%b", i, bus.redirect_pend, e.pend); end
        end
    endtask

    task automatic test_misalign();
        stim_t sq[$];
        exp_t  xq[$];
        exp_t  e;
        sq.push_back(s(0, 0, 1, 0, 0, 0, 1, 32'h1002, 0, 0));          xq.push_back(x(32'h80, 0, 1, 1));
        sq.push_back(idle());                                          xq.push_back(x(32'h84, 0, 0, 1));
        sq.push_back(s(0, 0, 1, 0, 0, 0, 1, 32'h1004, 0, 0));          xq.push_back(x(32'h1004, 0, 0, 1));
        sq.push_back(s(0, 1, 1, 0, 0, 0, 1, 32'h1001, 0, 0));          xq.push_back(x(32'h1004, 1, 1, 1));
        sq.push_back(s(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));                 xq.push_back(x(32'h1004, 1, 0, 1));
        sq.push_back(idle());                                          xq.push_back(x(32'h80, 0, 0, 1));
        sq.push_back(idle());                                          xq.push_back(x(32'h84, 0, 0, 1));
        sq.push_back(s(0, 0, 1, 0, 1, 32'h2000, 1, 32'h3003, 0, 0));   xq.push_back(x(32'h80, 0, 1, 1));
        sq.push_back(s(0, 0, 1, 0, 0, 0, 1, 32'h3000, 1, 32'h4000));   xq.push_back(x(32'h3000, 0, 0, 1));
        foreach (sq[i]) begin
            drive(sq[i]); sb.push_back(xq[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++; if (bus.pc !== e.pc) begin failures++; $display("FAIL misalign[%0d] pc got=%h exp=%h", i, bus.pc, e.pc); end
            checks++; if (bus.redirect_pend !== e.pend) begin failures++; $display("FAIL misalign[%0d] redirect_pend got=%b exp=%b", i, bus.redirect_pend, e.pend); end
            checks++; if (bus.misalign !== e.mis) begin failures++; $display("FAIL misalign[%0d] misalign got=%b exp=%b", i, bus.misalign, e.mis); end
        end
    endtask

    task automatic test_wrap_and_reset();
        stim_t sq[$];
        exp_t  xq[$];
        exp_t  e;
        logic [31:0] p4;
        sq.push_back(s(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC));     xq.push_back(x(32'hFFFF_FFFC, 0, 0, 1));
        sq.push_back(idle());                                          xq.push_back(x(32'h0, 0, 0, 1));
        sq.push_back(s(0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h900));           xq.push_back(x(32'h0, 1, 0, 1));
        sq.push_back(s(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));                 xq.push_back(x(32'h0, 0, 0, 0));
        sq.push_back(idle());                                          xq.push_back(x(32'h0, 0, 0, 1));
        sq.push_back(idle());                                          xq.push_back(x(32'h4, 0, 0, 1));
        foreach (sq[i]) begin
            drive(sq[i]); sb.push_back(xq[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); p4 = e.pc + 32'd4;
            checks++; if (bus.pc !== e.pc) begin failures++; $display("FAIL wrap[%0d] pc got=%h exp=%h", i, bus.pc, e.pc); end
            checks++; if (bus.pc_plus_4 !== p4) begin failures++; $display("FAIL wrap[%0d] pc_plus_4 got=%h exp=%h", i, bus.pc_plus_4, p4); end
            checks++; if (bus.redirect_pend !== e.pend) begin failures++; $display("FAIL wrap[%0d] redirect_pend got=%b exp=%b", i, bus.redirect_pend, e.pend); end
            checks++; if (bus.fetch_valid !== e.fv) begin failures++; $display("FAIL wrap[%0d] fetch_valid got=%b exp=%b", i, bus.fetch_valid, e.fv); end
        end
    endtask

    initial begin
        drive(s(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_branch_priority();
        test_stall_hold();
        test_pending_priority();
        test_misalign();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
